// File: rtl/hit_damage_ctrl.sv
// Player hit handler: turns collision levels into single life-decrement pulses,
// runs a pausable invincibility window after each hit and latches game-over.
module hit_damage_ctrl #(
    parameter int unsigned GRACE_CYCLES = 50_000_000,
    parameter int unsigned CNT_W        = 26,
    parameter int unsigned BLINK_BIT    = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_hit,
    input  logic       i_pause,
    input  logic [2:0] i_life_count,
    output logic       o_minus_life,
    output logic       o_invincible,
    output logic       o_blink,
    output logic       o_game_over
);

    localparam logic [CNT_W-1:0] GRACE_INIT = CNT_W'(GRACE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_PULSE = 2'd1,
        ST_GRACE = 2'd2,
        ST_DEAD  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_hit_d;
    logic [CNT_W-1:0] r_grace_cnt;
    logic             r_minus_life;
    logic             r_invincible;
    logic             r_blink;
    logic             r_game_over;

    logic             w_hit_evt;
    logic [CNT_W-1:0] w_cnt_dec;

    // A rising edge seen while paused is dropped, not deferred.
    assign w_hit_evt = i_hit & ~r_hit_d & ~i_pause;
    assign w_cnt_dec = r_grace_cnt - CNT_W'(1);

    // Outputs are registered alongside the state so they always match it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_ALIVE;
            r_hit_d      <= 1'b0;
            r_grace_cnt  <= '0;
            r_minus_life <= 1'b0;
            r_invincible <= 1'b0;
            r_blink      <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_hit_d <= i_hit;
            case (r_state)
                ST_ALIVE: begin
                    if (i_life_count == 3'd0) begin
                        r_state     <= ST_DEAD;
                        r_game_over <= 1'b1;
                    end else if (w_hit_evt) begin
                        r_state      <= ST_PULSE;
                        r_minus_life <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    r_minus_life <= 1'b0;
                    // Life count still shows the pre-decrement value here.
                    if (i_life_count <= 3'd1) begin
                        r_state     <= ST_DEAD;
                        r_game_over <= 1'b1;
                    end else begin
                        r_state      <= ST_GRACE;
                        r_grace_cnt  <= GRACE_INIT;
                        r_invincible <= 1'b1;
                        r_blink      <= GRACE_INIT[BLINK_BIT];
                    end
                end
                ST_GRACE: begin
                    if (!i_pause) begin
                        if (r_grace_cnt == '0) begin
                            r_state      <= ST_ALIVE;
                            r_invincible <= 1'b0;
                            r_blink      <= 1'b0;
                        end else begin
                            r_grace_cnt <= w_cnt_dec;
                            r_blink     <= w_cnt_dec[BLINK_BIT];
                        end
                    end
                end
                ST_DEAD: begin
                    r_state <= ST_DEAD;
                end
            endcase
        end
    end

    assign o_minus_life = r_minus_life;
    assign o_invincible = r_invincible;
    assign o_blink      = r_blink;
    assign o_game_over  = r_game_over;

endmodule

// File: tb/tb_hit_damage_ctrl.sv
// Bench for hit_damage_ctrl: directed scenarios plus random traffic, checked
// cycle by cycle against a behavioural model and a closed-loop life counter.
module tb_hit_damage_ctrl;

    localparam int unsigned G  = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned BB = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_hit;
    logic       i_pause;
    logic [2:0] i_life_count;
    logic       o_minus_life;
    logic       o_invincible;
    logic       o_blink;
    logic       o_game_over;

    hit_damage_ctrl #(
        .GRACE_CYCLES (G),
        .CNT_W        (CW),
        .BLINK_BIT    (BB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_hit        (i_hit),
        .i_pause      (i_pause),
        .i_life_count (i_life_count),
        .o_minus_life (o_minus_life),
        .o_invincible (o_invincible),
        .o_blink      (o_blink),
        .o_game_over  (o_game_over)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: dead flag, pulse flag, and remaining grace cycles (0 = not in grace).
    bit m_dead;
    bit m_pulse;
    int m_grace_left;
    bit m_prev_hit;

    bit closed_loop;
    int life;
    bit last_minus;
    int pulses;
    int inv_cycles;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit hit, input bit pause, input int lc);
        bit evt;
        evt = hit && !m_prev_hit && !pause;
        m_prev_hit = hit;
        if (m_dead) begin
            m_dead = 1'b1;
        end else if (m_pulse) begin
            m_pulse = 1'b0;
            if (lc <= 1) m_dead = 1'b1;
            else         m_grace_left = G;
        end else if (m_grace_left > 0) begin
            if (!pause) m_grace_left = m_grace_left - 1;
        end else begin
            if (lc == 0)  m_dead = 1'b1;
            else if (evt) m_pulse = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic exp_blink;
        exp_blink = (m_grace_left > 0) ? 1'(((m_grace_left - 1) >> BB) & 1) : 1'b0;
        chk({tag, "_minus"}, o_minus_life, m_pulse);
        chk({tag, "_inv"},   o_invincible, 1'(m_grace_left > 0));
        chk({tag, "_blink"}, o_blink,      exp_blink);
        chk({tag, "_over"},  o_game_over,  m_dead);
    endtask

    // One clock cycle: drive at negedge, sample 1 time unit after posedge.
    task automatic step(input bit hit, input bit pause, input string tag);
        int lc;
        i_hit   = hit;
        i_pause = pause;
        if (closed_loop) i_life_count = 3'(life);
        lc = int'(i_life_count);
        @(posedge clk);
        if (closed_loop && last_minus) life = (life + 7) % 8;
        model_update(hit, pause, lc);
        #1;
        check_outputs(tag);
        last_minus = o_minus_life;
        if (o_minus_life) pulses++;
        if (o_invincible) inv_cycles++;
        @(negedge clk);
    endtask

    // Asynchronous reset applied between clock edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        i_hit = 1'b0;
        i_pause = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        m_dead = 0; m_pulse = 0; m_grace_left = 0; m_prev_hit = 0;
        life = 3; last_minus = 0;
        check_outputs({tag, "_async"});
        @(posedge clk);
        #1;
        check_outputs({tag, "_held"});
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        inv_cycles = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        i_hit = 1'b0;
        i_pause = 1'b0;
        i_life_count = 3'd3;
        closed_loop = 1'b0;
        life = 3;
        @(negedge clk);
        do_reset("init");

        // Reset in the middle of a grace window.
        step(1, 0, "t1_hit");
        step(0, 0, "t1_pulse");
        step(0, 0, "t1_g1");
        step(0, 0, "t1_g2");
        do_reset("t1_rst");
        step(0, 0, "t1_after");
        chk_int("t1_no_pulse", pulses, 0);

        // Single held hit.
        do_reset("t2_rst");
        i_life_count = 3'd3;
        step(0, 0, "t2_idle");
        for (int i = 0; i < 20; i++) step(1, 0, "t2_held");
        for (int i = 0; i < 3; i++) step(0, 0, "t2_rel");
        chk_int("t2_pulses", pulses, 1);
        chk_int("t2_inv_len", inv_cycles, 8);

        // Edges inside grace masked, edge after grace counted.
        do_reset("t3_rst");
        begin
            bit pat [12] = '{0,0,1,0,0,1,0,0,0,0,0,1};
            step(1, 0, "t3_hit");
            for (int i = 0; i < 12; i++) step(pat[i], 0, "t3_seq");
            step(0, 0, "t3_tail");
            step(0, 0, "t3_tail");
        end
        chk_int("t3_pulses", pulses, 2);

        // Last life.
        do_reset("t4_rst");
        i_life_count = 3'd1;
        step(0, 0, "t4_idle");
        step(1, 0, "t4_hit");
        step(0, 0, "t4_dead");
        for (int i = 0; i < 10; i++) step(1'(i % 2), 0, "t4_more");
        chk_int("t4_pulses", pulses, 1);
        chk("t4_sticky", o_game_over, 1'b1);

        // Zero lives while alive.
        do_reset("t4b_rst");
        i_life_count = 3'd0;
        step(0, 0, "t4b_zero");
        chk("t4b_over", o_game_over, 1'b1);

        // Pause stretches grace; paused edge in alive is lost.
        do_reset("t5_rst");
        i_life_count = 3'd3;
        step(1, 0, "t5_hit");
        for (int i = 0; i < 3; i++) step(0, 0, "t5_g");
        for (int i = 0; i < 5; i++) step(0, 1, "t5_p");
        for (int i = 0; i < 10; i++) step(0, 0, "t5_g2");
        chk_int("t5_inv_len", inv_cycles, 13);
        step(1, 1, "t5_phit");
        step(1, 0, "t5_held");
        step(0, 0, "t5_rel");
        step(0, 0, "t5_rel");
        chk_int("t5_pulses", pulses, 1);

        // Closed loop with the life counter.
        closed_loop = 1'b1;
        do_reset("t6_rst");
        for (int h = 0; h < 3; h++) begin
            step(1, 0, "t6_hit");
            for (int i = 0; i < 12; i++) step(0, 0, "t6_gap");
        end
        chk_int("t6_life", life, 0);
        chk("t6_over", o_game_over, 1'b1);
        for (int i = 0; i < 6; i++) step(1'(i % 2), 0, "t6_more");
        chk_int("t6_life_nowrap", life, 0);
        chk_int("t6_pulses", pulses, 3);

        // Random closed-loop traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset("r1_rst");
            step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0), "r1");
        end

        // Random open-loop traffic with arbitrary life counts.
        closed_loop = 1'b0;
        do_reset("r2_rst");
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) do_reset("r2_rst");
            i_life_count = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 1))
                                                        : 3'($urandom_range(2, 7));
            step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0), "r2");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
